// File: rtl/i2s_clkws_cfg_seq.sv
// Glitch-safe reconfiguration sequencer owning the I2S clock/WS generator enables and configuration.
// Latency: fast path (enables only) done in cycle 1; full path done in cycle N+2+SETTLE_CYCLES after commit.
// No backpressure: commits while busy are dropped and flagged on the sticky err_o.
module i2s_clkws_cfg_seq #(
    parameter int SYNC_MARGIN   = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cfg_commit_i,
    input  logic        cfg_master_en_i,
    input  logic        cfg_slave_en_i,
    input  logic        cfg_pdm_en_i,
    input  logic [15:0] cfg_div_0_i,
    input  logic [15:0] cfg_div_1_i,
    input  logic        cfg_sel_master_num_i,
    input  logic        cfg_sel_master_ext_i,
    input  logic        cfg_sel_slave_num_i,
    input  logic        cfg_sel_slave_ext_i,
    input  logic [4:0]  cfg_word_size_0_i,
    input  logic [4:0]  cfg_word_size_1_i,
    input  logic [3:0]  cfg_word_num_0_i,
    input  logic [3:0]  cfg_word_num_1_i,
    input  logic        err_clr_i,
    output logic        master_en_o,
    output logic        slave_en_o,
    output logic        pdm_en_o,
    output logic [15:0] div_0_o,
    output logic [15:0] div_1_o,
    output logic        sel_master_num_o,
    output logic        sel_master_ext_o,
    output logic        sel_slave_num_o,
    output logic        sel_slave_ext_o,
    output logic [4:0]  word_size_0_o,
    output logic [4:0]  word_size_1_o,
    output logic [3:0]  word_num_0_o,
    output logic [3:0]  word_num_1_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    // Non-enable configuration, compared as a whole to pick fast or full path.
    typedef struct packed {
        logic [15:0] div_0;
        logic [15:0] div_1;
        logic        sel_master_num;
        logic        sel_master_ext;
        logic        sel_slave_num;
        logic        sel_slave_ext;
        logic [4:0]  word_size_0;
        logic [4:0]  word_size_1;
        logic [3:0]  word_num_0;
        logic [3:0]  word_num_1;
    } cfg_t;

    typedef struct packed {
        logic master;
        logic slave;
        logic pdm;
    } en_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISABLE,
        S_DRAIN,
        S_APPLY,
        S_SETTLE,
        S_ENABLE
    } state_t;

    // The APPLY cycle is the first settle cycle, so SETTLE itself lasts one less.
    localparam logic [17:0] SETTLE_LOAD = 18'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [17:0] cnt, cnt_nxt;
    cfg_t        req_cfg, pend_cfg, act_cfg, act_cfg_nxt;
    en_t         req_en, pend_en, act_en, act_en_nxt;
    logic        capture;
    logic        busy_q, done_q, err_q, err_nxt;
    logic [15:0] div_max;
    logic [16:0] div_max_p1;
    logic [17:0] drain_n;

    // Pack the request side and size the drain from the currently active dividers.
    always_comb begin
        req_cfg.div_0          = cfg_div_0_i;
        req_cfg.div_1          = cfg_div_1_i;
        req_cfg.sel_master_num = cfg_sel_master_num_i;
        req_cfg.sel_master_ext = cfg_sel_master_ext_i;
        req_cfg.sel_slave_num  = cfg_sel_slave_num_i;
        req_cfg.sel_slave_ext  = cfg_sel_slave_ext_i;
        req_cfg.word_size_0    = cfg_word_size_0_i;
        req_cfg.word_size_1    = cfg_word_size_1_i;
        req_cfg.word_num_0     = cfg_word_num_0_i;
        req_cfg.word_num_1     = cfg_word_num_1_i;
        req_en.master          = cfg_master_en_i;
        req_en.slave           = cfg_slave_en_i;
        req_en.pdm             = cfg_pdm_en_i;
        div_max    = (act_cfg.div_0 > act_cfg.div_1) ? act_cfg.div_0 : act_cfg.div_1;
        div_max_p1 = {1'b0, div_max} + 17'd1;
        // 2*(0xFFFF+1) needs 18 bits; the margin is small enough not to carry out.
        drain_n    = {div_max_p1, 1'b0} + 18'(SYNC_MARGIN);
    end

    // Next-state, counter and active-config decisions.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        act_cfg_nxt = act_cfg;
        act_en_nxt  = act_en;
        capture     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cfg_commit_i) begin
                    capture = 1'b1;
                    if (req_cfg == act_cfg) begin
                        state_nxt  = S_ENABLE;
                        act_en_nxt = req_en;
                    end else begin
                        state_nxt  = S_DISABLE;
                        act_en_nxt = '0;
                        // Nothing was running, so there is no divided clock to drain.
                        cnt_nxt    = (act_en == '0) ? 18'd0 : drain_n;
                    end
                end
            end
            S_DISABLE: begin
                if (cnt == 18'd0) begin
                    state_nxt   = S_APPLY;
                    act_cfg_nxt = pend_cfg;
                end else begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt <= 18'd1) begin
                    state_nxt   = S_APPLY;
                    cnt_nxt     = 18'd0;
                    act_cfg_nxt = pend_cfg;
                end else begin
                    cnt_nxt = cnt - 18'd1;
                end
            end
            S_APPLY: begin
                if (SETTLE_LOAD == 18'd0) begin
                    state_nxt  = S_ENABLE;
                    act_en_nxt = pend_en;
                end else begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (cnt <= 18'd1) begin
                    state_nxt  = S_ENABLE;
                    cnt_nxt    = 18'd0;
                    act_en_nxt = pend_en;
                end else begin
                    cnt_nxt = cnt - 18'd1;
                end
            end
            S_ENABLE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sticky error: a commit outside IDLE sets it, and set beats clear.
    always_comb begin
        err_nxt = err_q;
        if (cfg_commit_i && (state != S_IDLE)) begin
            err_nxt = 1'b1;
        end else if (err_clr_i) begin
            err_nxt = 1'b0;
        end
    end

    // State, counter, pending and active registers; reset aborts any sequence.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pend_cfg <= '0;
            pend_en  <= '0;
            act_cfg  <= '0;
            act_en   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            act_cfg <= act_cfg_nxt;
            act_en  <= act_en_nxt;
            busy_q  <= (state_nxt != S_IDLE);
            done_q  <= (state_nxt == S_ENABLE);
            err_q   <= err_nxt;
            if (capture) begin
                pend_cfg <= req_cfg;
                pend_en  <= req_en;
            end
        end
    end

    assign master_en_o      = act_en.master;
    assign slave_en_o       = act_en.slave;
    assign pdm_en_o         = act_en.pdm;
    assign div_0_o          = act_cfg.div_0;
    assign div_1_o          = act_cfg.div_1;
    assign sel_master_num_o = act_cfg.sel_master_num;
    assign sel_master_ext_o = act_cfg.sel_master_ext;
    assign sel_slave_num_o  = act_cfg.sel_slave_num;
    assign sel_slave_ext_o  = act_cfg.sel_slave_ext;
    assign word_size_0_o    = act_cfg.word_size_0;
    assign word_size_1_o    = act_cfg.word_size_1;
    assign word_num_0_o     = act_cfg.word_num_0;
    assign word_num_1_o     = act_cfg.word_num_1;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_i2s_clkws_cfg_seq.sv
// Bench for i2s_clkws_cfg_seq: drives commits, predicts per-cycle outputs and done timing.
// Latency: expected done cycle pushed per commit, popped when done_o is seen.
// No backpressure on the DUT; busy commits are injected deliberately.
module tb_i2s_clkws_cfg_seq;

    localparam int SM     = 4;
    localparam int SETTLE = 4;

    typedef struct packed {
        logic [15:0] div_0;
        logic [15:0] div_1;
        logic        sel_master_num;
        logic        sel_master_ext;
        logic        sel_slave_num;
        logic        sel_slave_ext;
        logic [4:0]  word_size_0;
        logic [4:0]  word_size_1;
        logic [3:0]  word_num_0;
        logic [3:0]  word_num_1;
    } cfg_t;

    typedef struct packed {
        logic master;
        logic slave;
        logic pdm;
    } en_t;

    typedef struct {
        int   done_cyc;
        cfg_t cfg;
        en_t  en;
    } exp_t;

    logic clk;
    logic rstn;
    logic commit;
    logic err_clr;
    cfg_t req_cfg;
    en_t  req_en;

    logic        master_en_o, slave_en_o, pdm_en_o;
    logic [15:0] div_0_o, div_1_o;
    logic        sel_master_num_o, sel_master_ext_o, sel_slave_num_o, sel_slave_ext_o;
    logic [4:0]  word_size_0_o, word_size_1_o;
    logic [3:0]  word_num_0_o, word_num_1_o;
    logic        busy_o, done_o, err_o;

    cfg_t out_cfg;
    en_t  out_en;

    cfg_t m_cfg;
    en_t  m_en;
    logic m_err;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    i2s_clkws_cfg_seq #(
        .SYNC_MARGIN   (SM),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk_i                (clk),
        .rstn_i               (rstn),
        .cfg_commit_i         (commit),
        .cfg_master_en_i      (req_en.master),
        .cfg_slave_en_i       (req_en.slave),
        .cfg_pdm_en_i         (req_en.pdm),
        .cfg_div_0_i          (req_cfg.div_0),
        .cfg_div_1_i          (req_cfg.div_1),
        .cfg_sel_master_num_i (req_cfg.sel_master_num),
        .cfg_sel_master_ext_i (req_cfg.sel_master_ext),
        .cfg_sel_slave_num_i  (req_cfg.sel_slave_num),
        .cfg_sel_slave_ext_i  (req_cfg.sel_slave_ext),
        .cfg_word_size_0_i    (req_cfg.word_size_0),
        .cfg_word_size_1_i    (req_cfg.word_size_1),
        .cfg_word_num_0_i     (req_cfg.word_num_0),
        .cfg_word_num_1_i     (req_cfg.word_num_1),
        .err_clr_i            (err_clr),
        .master_en_o          (master_en_o),
        .slave_en_o           (slave_en_o),
        .pdm_en_o             (pdm_en_o),
        .div_0_o              (div_0_o),
        .div_1_o              (div_1_o),
        .sel_master_num_o     (sel_master_num_o),
        .sel_master_ext_o     (sel_master_ext_o),
        .sel_slave_num_o      (sel_slave_num_o),
        .sel_slave_ext_o      (sel_slave_ext_o),
        .word_size_0_o        (word_size_0_o),
        .word_size_1_o        (word_size_1_o),
        .word_num_0_o         (word_num_0_o),
        .word_num_1_o         (word_num_1_o),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .err_o                (err_o)
    );

    assign out_cfg = {div_0_o, div_1_o, sel_master_num_o, sel_master_ext_o,
                      sel_slave_num_o, sel_slave_ext_o, word_size_0_o, word_size_1_o,
                      word_num_0_o, word_num_1_o};
    assign out_en  = {master_en_o, slave_en_o, pdm_en_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Commit c/e in cycle 0 and check every cycle through done+1; n<0 selects the fast path.
    // A second commit is injected in cycle 'bad' (0 = none), optionally with err_clr.
    task automatic run_commit(input string name, input cfg_t c, input en_t e, input int n,
                              input int bad, input logic clr_at_bad);
        int   done_c, apply_c;
        exp_t ex, got;
        cfg_t exp_c, junk;
        en_t  exp_e;
        logic exp_err;
        apply_c = (n < 0) ? 1 : n + 2;
        done_c  = (n < 0) ? 1 : n + 2 + SETTLE;
        ex.done_cyc = done_c;
        ex.cfg      = c;
        ex.en       = e;
        sb.push_back(ex);
        junk = c;
        junk.div_0      = c.div_0 ^ 16'h00a5;
        junk.word_num_1 = ~c.word_num_1;
        req_cfg = c;
        req_en  = e;
        commit  = 1'b1;
        for (int cy = 1; cy <= done_c + 1; cy++) begin
            @(negedge clk);
            commit  = 1'b0;
            err_clr = 1'b0;
            req_cfg = c;
            req_en  = e;
            exp_c   = (cy >= apply_c) ? c : m_cfg;
            exp_e   = (cy >= done_c) ? e : en_t'(3'b000);
            exp_err = (bad > 0 && cy > bad) ? 1'b1 : m_err;
            n_cmp++;
            if (busy_o !== (cy <= done_c)) begin
                n_bad++;
                $display("FAIL %s cyc%0d busy: got %0b want %0b", name, cy, busy_o, (cy <= done_c));
            end
            n_cmp++;
            if (done_o !== (cy == done_c)) begin
                n_bad++;
                $display("FAIL %s cyc%0d done: got %0b want %0b", name, cy, done_o, (cy == done_c));
            end
            n_cmp++;
            if (out_cfg !== exp_c) begin
                n_bad++;
                $display("FAIL %s cyc%0d cfg: got %h want %h", name, cy, out_cfg, exp_c);
            end
            n_cmp++;
            if (out_en !== exp_e) begin
                n_bad++;
                $display("FAIL %s cyc%0d en: got %b want %b", name, cy, out_en, exp_e);
            end
            n_cmp++;
            if (err_o !== exp_err) begin
                n_bad++;
                $display("FAIL %s cyc%0d err: got %0b want %0b", name, cy, err_o, exp_err);
            end
            if (done_o === 1'b1) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s cyc%0d sb_done: got unexpected done want none", name, cy);
                end else begin
                    got = sb.pop_front();
                    if (got.done_cyc != cy || got.cfg !== out_cfg || got.en !== out_en) begin
                        n_bad++;
                        $display("FAIL %s sb_done: got cyc%0d cfg %h en %b want cyc%0d cfg %h en %b",
                                 name, cy, out_cfg, out_en, got.done_cyc, got.cfg, got.en);
                    end
                end
            end
            if (cy == bad) begin
                req_cfg = junk;
                req_en  = ~e;
                commit  = 1'b1;
                err_clr = clr_at_bad;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s sb_timeout: got %0d outstanding want 0", name, sb.size());
            sb.delete();
        end
        m_cfg = c;
        m_en  = e;
        if (bad > 0) m_err = 1'b1;
    endtask

    task automatic test_reset;
        rstn    = 1'b0;
        commit  = 1'b0;
        err_clr = 1'b0;
        req_cfg = '0;
        req_en  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy_o, done_o, err_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset flags: got %b want 000", {busy_o, done_o, err_o});
        end
        n_cmp++;
        if (out_en !== en_t'(3'b000)) begin
            n_bad++;
            $display("FAIL reset en: got %b want 000", out_en);
        end
        n_cmp++;
        if (out_cfg !== cfg_t'(0)) begin
            n_bad++;
            $display("FAIL reset cfg: got %h want 0", out_cfg);
        end
        rstn  = 1'b1;
        m_cfg = '0;
        m_en  = '0;
        m_err = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset busy_after_release: got %0b want 0", busy_o);
        end
    endtask

    task automatic test_skip_drain;
        cfg_t c;
        c = '0;
        c.div_1         = 16'd5;
        c.sel_slave_ext = 1'b1;
        run_commit("skip_drain", c, en_t'(3'b000), 0, 0, 1'b0);
    endtask

    task automatic test_full_path;
        cfg_t c;
        c = '0;
        c.div_0 = 16'd3;
        c.div_1 = 16'd1;
        run_commit("setup_div3", c, en_t'(3'b100), 0, 0, 1'b0);
        c.div_0 = 16'd7;
        run_commit("full_div7", c, en_t'(3'b100), 12, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        cfg_t c;
        c = '0;
        c.div_0       = 16'd3;
        c.div_1       = 16'd1;
        c.word_size_0 = 5'd16;
        run_commit("b2b_div3", c, en_t'(3'b100), 20, 0, 1'b0);
    endtask

    task automatic test_busy_commit;
        cfg_t c;
        c = '0;
        c.div_0 = 16'd7;
        c.div_1 = 16'd1;
        run_commit("busy_commit", c, en_t'(3'b100), 12, 5, 1'b0);
    endtask

    task automatic test_err_clear;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clr_alone: got %0b want 0", err_o);
        end
        run_commit("fast_clr_vs_set", m_cfg, en_t'(3'b111), -1, 1, 1'b1);
        n_cmp++;
        if (err_o !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set_wins: got %0b want 1", err_o);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic test_fast_path;
        run_commit("fast_slave_en", m_cfg, en_t'(3'b110), -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_drain;
        cfg_t c;
        int   viol;
        c = m_cfg;
        c.div_0 = 16'hffff;
        run_commit("load_ffff", c, en_t'(3'b100), 20, 0, 1'b0);
        c.div_0 = 16'd2;
        req_cfg = c;
        req_en  = en_t'(3'b100);
        commit  = 1'b1;
        viol    = 0;
        for (int cy = 1; cy <= 2000; cy++) begin
            @(negedge clk);
            commit = 1'b0;
            if (busy_o !== 1'b1 || done_o !== 1'b0 || out_en !== en_t'(3'b000) || div_0_o !== 16'hffff)
                viol++;
        end
        n_cmp++;
        if (viol != 0) begin
            n_bad++;
            $display("FAIL long_drain: got %0d early-exit cycles want 0", viol);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, done_o, err_o, out_en, out_cfg} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_drain: got busy %0b done %0b en %b cfg %h want all 0",
                     busy_o, done_o, out_en, out_cfg);
        end
        @(negedge clk);
        rstn  = 1'b1;
        m_cfg = '0;
        m_en  = '0;
        m_err = 1'b0;
        sb.delete();
        run_commit("fast_after_reset", cfg_t'(0), en_t'(3'b100), -1, 0, 1'b0);
        run_commit("fast_all_off", cfg_t'(0), en_t'(3'b000), -1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_skip_drain();
        test_full_path();
        test_back_to_back();
        test_busy_commit();
        test_err_clear();
        test_fast_path();
        test_reset_mid_drain();
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL final_idle: got busy %0b want 0", busy_o);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
